mem_writeback: RTL
==================

Name: mem_writeback

Overview:
- MEM stage and MEM/WB pipeline register of the 5-stage MIPS pipeline.
- Consumes the EM_* bundle produced by the ID/EX block and generates the MW_* bundle that the ID/EX block uses for register-file writeback and forwarding.
- Holds the word-addressed data memory, with configurable access latency and a stall handshake.
- Resolves taken branches from EM_Branch/EM_ZERO.

Parameters:
- DEPTH, 64, number of 32-bit data memory words; power of 2.
- MEM_LATENCY, 0, extra wait cycles per lw/sw (0 = single-cycle access); legal range 0..7.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- EM_MemtoReg  in  1  load result selects memory data
- EM_RegWrite  in  1  instruction writes a register
- EM_MemRead  in  1  lw access
- EM_MemWrite  in  1  sw access
- EM_Branch  in  1  beq/bne in MEM stage
- EM_ZERO  in  1  branch-taken condition (already inverted for bne upstream)
- EM_Result  in  32  ALU result / byte address
- EM_Rd  in  5  destination register
- EM_PC2_ADD_out  in  32  branch target
- EM_Readdata2  in  32  sw store data
- EM_Instruction  in  32  instruction in MEM
- MW_RegWrite  out  1  registered writeback enable
- MW_MemtoReg  out  1  registered select
- MW_MemData  out  32  registered load data
- MW_Result  out  32  registered ALU result
- MW_RD  out  5  registered destination
- MW_Instruction  out  32  registered instruction (used for forwarding compare)
- PCSrc  out  1  branch taken, combinational
- Branch_target  out  32  = EM_PC2_ADD_out, combinational
- Mem_Stall  out  1  upstream must hold PC, IF/ID, ID/EX and EM registers
- Mem_AddrErr  out  1  sticky illegal-access flag

Behaviour:
- Reset (async):
  - All MW_* outputs clear to 0.
  - Mem_AddrErr clears to 0.
  - FSM goes to IDLE and the wait counter clears to 0.
  - Memory contents are not reset.
- Address:
  - Word index = EM_Result[log2(DEPTH)+1:2].
  - The access is legal only if EM_Result[1:0]==0 and EM_Result < 4*DEPTH.
- Illegal access (lw or sw):
  - Nothing is written to memory.
  - Load data is forced to 0.
  - Mem_AddrErr is set on the completing edge and stays high until rst.
  - The instruction still completes normally.
- PCSrc = EM_Branch & EM_ZERO. It does not depend on the FSM.
- FSM states: IDLE, WAIT.
  - IDLE:
    - If (EM_MemRead|EM_MemWrite) and MEM_LATENCY>0: Mem_Stall=1, load cnt=MEM_LATENCY-1, go to WAIT.
    - Otherwise the access completes this cycle.
  - WAIT:
    - Mem_Stall=1 while cnt!=0, decrement cnt each cycle.
    - When cnt==0: Mem_Stall=0, the access completes, go to IDLE.
  - Total cycles in MEM for an access = MEM_LATENCY+1. Mem_Stall is high for exactly MEM_LATENCY of them and low on the completing cycle.
- Completing cycle, rising edge:
  - sw writes EM_Readdata2 to the addressed word.
  - MW register loads: RegWrite, MemtoReg, Rd, Instruction, Result from the EM_* inputs; MemData from a combinational read of the memory at this address.
  - A read in the same cycle as a write to the same word cannot occur (one access per instruction).
- Stall cycles (Mem_Stall=1):
  - The MW register loads a bubble: MW_RegWrite=0, MW_MemtoReg=0, MW_RD=0, MW_Instruction=0.
  - MW_Result and MW_MemData hold their values.
  - Memory is not written, so a sw commits exactly once.
- Upstream contract: EM_* inputs stay stable while Mem_Stall=1. The block does not latch them.
- Non-memory instructions: the MW register loads every cycle. MW_MemData loads the read data at the addressed word if legal, else 0.
- MEM_LATENCY=0: the FSM never leaves IDLE and Mem_Stall is constantly 0.
- Reset asserted during WAIT aborts the access: no write, FSM goes to IDLE.

Test Plan:
- MEM_LATENCY=0; sw with EM_Result=0x10, EM_Readdata2=0xDEADBEEF, then lw to 0x10 with EM_MemtoReg=1, EM_RegWrite=1, EM_Rd=8 -> on the cycle after the lw, MW_MemData=0xDEADBEEF, MW_RD=8, MW_RegWrite=1; Mem_Stall never asserts.
- MEM_LATENCY=3; lw to 0x20 preloaded with 0x5 -> Mem_Stall high exactly 3 cycles; MW_RegWrite=0 during those edges; on the 4th edge MW_MemData=0x5 and MW_RegWrite=1.
- MEM_LATENCY=2; sw 0x77 to 0x8 held for 3 cycles, then a second sw 0x99 to the same address -> the word holds 0x77 after the first completes and 0x99 after the second; no extra writes occur during stalls.
- EM_Branch=1, EM_ZERO=1, EM_PC2_ADD_out=0x40 -> PCSrc=1 and Branch_target=0x40 in the same cycle; with EM_ZERO=0 -> PCSrc=0.
- lw with EM_Result=0x6, then sw with EM_Result=4*DEPTH -> both give Mem_AddrErr=1 sticky; the lw returns MW_MemData=0; no memory word changes; the flag clears only on rst.
- MEM_LATENCY=3; assert rst in the 2nd stall cycle of a sw -> all MW_* outputs become 0, Mem_Stall=0, the target word is unchanged.

Source files
------------

// File: rtl/mem_writeback.sv
// MEM stage and MEM/WB pipeline register: word-addressed data memory with
// configurable access latency and stall handshake, branch resolution, and writeback bundle.
module mem_writeback #(
    parameter int DEPTH       = 64,
    parameter int MEM_LATENCY = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        EM_MemtoReg,
    input  logic        EM_RegWrite,
    input  logic        EM_MemRead,
    input  logic        EM_MemWrite,
    input  logic        EM_Branch,
    input  logic        EM_ZERO,
    input  logic [31:0] EM_Result,
    input  logic [4:0]  EM_Rd,
    input  logic [31:0] EM_PC2_ADD_out,
    input  logic [31:0] EM_Readdata2,
    input  logic [31:0] EM_Instruction,
    output logic        MW_RegWrite,
    output logic        MW_MemtoReg,
    output logic [31:0] MW_MemData,
    output logic [31:0] MW_Result,
    output logic [4:0]  MW_RD,
    output logic [31:0] MW_Instruction,
    output logic        PCSrc,
    output logic [31:0] Branch_target,
    output logic        Mem_Stall,
    output logic        Mem_AddrErr
);

    localparam int          AW        = $clog2(DEPTH);
    localparam logic [31:0] MEM_BYTES = 32'(4 * DEPTH);
    localparam logic        HAS_WAIT  = (MEM_LATENCY > 0) ? 1'b1 : 1'b0;
    localparam logic [2:0]  CNT_LOAD  = (MEM_LATENCY > 0) ? 3'(MEM_LATENCY - 1) : 3'd0;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t        state_r;
    state_t        state_nx_s;
    logic [2:0]    cnt_r;
    logic [2:0]    cnt_nx_s;
    logic [31:0]   mem_r [DEPTH];
    logic [AW-1:0] idx_s;
    logic          legal_s;
    logic          mem_acc_s;
    logic          stall_s;
    logic          complete_s;
    logic [31:0]   rd_data_s;

    assign idx_s         = EM_Result[AW+1:2];
    assign legal_s       = (EM_Result[1:0] == 2'b00) && (EM_Result < MEM_BYTES);
    assign mem_acc_s     = EM_MemRead | EM_MemWrite;
    assign PCSrc         = EM_Branch & EM_ZERO;
    assign Branch_target = EM_PC2_ADD_out;
    assign Mem_Stall     = stall_s;

    // Combinational memory read; illegal addresses read as zero.
    always_comb begin
        rd_data_s = 32'h0000_0000;
        if (legal_s) begin
            rd_data_s = mem_r[idx_s];
        end else begin
            rd_data_s = 32'h0000_0000;
        end
    end

    // Access-latency FSM: next state, wait counter, stall and completion strobe.
    always_comb begin
        state_nx_s = state_r;
        cnt_nx_s   = cnt_r;
        stall_s    = 1'b0;
        complete_s = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (mem_acc_s && HAS_WAIT) begin
                    stall_s    = 1'b1;
                    cnt_nx_s   = CNT_LOAD;
                    state_nx_s = S_WAIT;
                end else begin
                    complete_s = 1'b1;
                end
            end
            S_WAIT: begin
                if (cnt_r != 3'd0) begin
                    stall_s  = 1'b1;
                    cnt_nx_s = cnt_r - 3'd1;
                end else begin
                    complete_s = 1'b1;
                    state_nx_s = S_IDLE;
                end
            end
            default: begin
                state_nx_s = S_IDLE;
                cnt_nx_s   = 3'd0;
            end
        endcase
    end

    // FSM state and wait-counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= S_IDLE;
            cnt_r   <= 3'd0;
        end else begin
            state_r <= state_nx_s;
            cnt_r   <= cnt_nx_s;
        end
    end

    // Store commits once, on the completing edge; an edge seen under reset never writes.
    always_ff @(posedge clk) begin
        if (complete_s && EM_MemWrite && legal_s && !rst) begin
            mem_r[idx_s] <= EM_Readdata2;
        end
    end

    // MEM/WB register: bubble while stalled (data fields hold), full load otherwise; sticky error flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            MW_RegWrite    <= 1'b0;
            MW_MemtoReg    <= 1'b0;
            MW_MemData     <= 32'h0000_0000;
            MW_Result      <= 32'h0000_0000;
            MW_RD          <= 5'd0;
            MW_Instruction <= 32'h0000_0000;
            Mem_AddrErr    <= 1'b0;
        end else begin
            if (stall_s) begin
                MW_RegWrite    <= 1'b0;
                MW_MemtoReg    <= 1'b0;
                MW_RD          <= 5'd0;
                MW_Instruction <= 32'h0000_0000;
            end else begin
                MW_RegWrite    <= EM_RegWrite;
                MW_MemtoReg    <= EM_MemtoReg;
                MW_MemData     <= rd_data_s;
                MW_Result      <= EM_Result;
                MW_RD          <= EM_Rd;
                MW_Instruction <= EM_Instruction;
            end
            if (complete_s && mem_acc_s && !legal_s) begin
                Mem_AddrErr <= 1'b1;
            end
        end
    end

endmodule
